// File: rtl/mux_4in_pkg.sv
// Shared select encoding for the small steering muxes.
//   sel_e    : 2-bit select code, {s1,s0}; SEL_I0..SEL_I3 pick i0..i3.
//   sel_code : packs the two select wires into a sel_e.
package mux_4in_pkg;

  typedef enum logic [1:0] {
    SEL_I0 = 2'b00,
    SEL_I1 = 2'b01,
    SEL_I2 = 2'b10,
    SEL_I3 = 2'b11
  } sel_e;

  function automatic sel_e sel_code(input logic s1, input logic s0);
    return sel_e'({s1, s0});
  endfunction

endpackage

// File: rtl/mux_4in_comb.sv
// Pure combinational 4:1 selector, bitwise per data bit.
// Ports:
//   i0..i3_i : WIDTH-bit data inputs
//   s1_i     : select MSB
//   s0_i     : select LSB
//   y_o      : selected data; all-X in simulation when the select is X/Z
module mux_4in_comb
  import mux_4in_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] i0_i,
  input  logic [WIDTH-1:0] i1_i,
  input  logic [WIDTH-1:0] i2_i,
  input  logic [WIDTH-1:0] i3_i,
  input  logic             s1_i,
  input  logic             s0_i,
  output logic [WIDTH-1:0] y_o
);

  sel_e sel;

  always_comb begin
    sel = sel_code(s1_i, s0_i);
    y_o = '0;
    case (sel)
      SEL_I0:  y_o = i0_i;
      SEL_I1:  y_o = i1_i;
      SEL_I2:  y_o = i2_i;
      SEL_I3:  y_o = i3_i;
      // Only reachable with an X/Z select: propagate X so a bad select is
      // visible downstream instead of silently picking an input.
      default: y_o = 'x;
    endcase
  end

endmodule

// File: rtl/mux_4in.sv
// 4:1 steering mux with an optional reset-defined output register.
// Ports:
//   clk      : rising-edge clock (unused when REG_OUT=0)
//   rst_n    : asynchronous active-low reset (unused when REG_OUT=0);
//              deassertion must already be synchronous to clk
//   i0..i3   : WIDTH-bit data, chosen by {s1,s0} = 00/01/10/11
//   s1, s0   : select MSB / LSB
//   out      : selected data, registered (REG_OUT=1) or combinational
//   out_comb : combinational selected data, never affected by reset
module mux_4in
  import mux_4in_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter int               REG_OUT   = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic             s0,
  input  logic             s1,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_comb
);

  if (WIDTH < 1) begin : g_bad_width
    $error("mux_4in: WIDTH must be >= 1");
  end
  if (REG_OUT != 0 && REG_OUT != 1) begin : g_bad_reg_out
    $error("mux_4in: REG_OUT must be 0 or 1");
  end

  mux_4in_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .i0_i (i0),
    .i1_i (i1),
    .i2_i (i2),
    .i3_i (i3),
    .s1_i (s1),
    .s0_i (s0),
    .y_o  (out_comb)
  );

  if (REG_OUT == 1) begin : g_reg
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;

    // No enable: the register reloads the current selection every cycle.
    assign out_d = out_comb;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q <= RESET_VAL;
      end else begin
        out_q <= out_d;
      end
    end

    assign out = out_q;

`ifndef SYNTHESIS
    // Sampled on the falling edge so the rising-edge update has settled.
    // chk_loaded_q is cleared asynchronously together with the output, so a
    // reset pulse between edges suppresses the following comparison.
    logic [WIDTH-1:0] chk_prev_q;
    logic             chk_loaded_q;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        chk_loaded_q <= 1'b0;
        chk_prev_q   <= RESET_VAL;
      end else begin
        chk_loaded_q <= 1'b1;
        chk_prev_q   <= out_comb;
      end
    end

    always @(negedge clk) begin
      if (!rst_n) begin
        a_out_reset : assert (out === RESET_VAL)
          else $error("mux_4in: out not at RESET_VAL during reset");
      end else if (chk_loaded_q) begin
        a_out_follow : assert (out === chk_prev_q)
          else $error("mux_4in: out differs from previous-cycle out_comb");
      end
    end
`endif
  end else begin : g_comb
    assign out = out_comb;
  end

endmodule

// File: tb/tb_mux_4in.sv
// Bench for mux_4in: three instances (1-bit registered, 8-bit registered,
// 1-bit combinational) against an array-indexed reference model.
module tb_mux_4in;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic       a_in [4];
  logic [1:0] a_sel;
  logic [7:0] b_in [4];
  logic [1:0] b_sel;
  logic       c_in [4];
  logic [1:0] c_sel;

  logic       a_out, a_out_comb;
  logic [7:0] b_out, b_out_comb;
  logic       c_out, c_out_comb;

  mux_4in #(.WIDTH(1), .REG_OUT(1), .RESET_VAL(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .i0(a_in[0]), .i1(a_in[1]), .i2(a_in[2]), .i3(a_in[3]),
    .s0(a_sel[0]), .s1(a_sel[1]),
    .out(a_out), .out_comb(a_out_comb)
  );

  mux_4in #(.WIDTH(8), .REG_OUT(1), .RESET_VAL(8'h00)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .i0(b_in[0]), .i1(b_in[1]), .i2(b_in[2]), .i3(b_in[3]),
    .s0(b_sel[0]), .s1(b_sel[1]),
    .out(b_out), .out_comb(b_out_comb)
  );

  mux_4in #(.WIDTH(1), .REG_OUT(0), .RESET_VAL(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .i0(c_in[0]), .i1(c_in[1]), .i2(c_in[2]), .i3(c_in[3]),
    .s0(c_sel[0]), .s1(c_sel[1]),
    .out(c_out), .out_comb(c_out_comb)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit done     = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a registered output shows whatever was selected at the last
  // rising edge taken out of reset; any reset since then shows zero.
  logic       cap_a;
  logic [7:0] cap_b;
  bit         mdl_valid = 1'b0;

  always @(posedge clk) begin
    if (rst_n) begin
      cap_a     = a_in[a_sel];
      cap_b     = b_in[b_sel];
      mdl_valid = 1'b1;
    end
  end

  always @(negedge rst_n) mdl_valid = 1'b0;

  // Compare process: every falling edge, all instances.
  always @(negedge clk) begin
    if (!done) begin
      check("a_out",      {7'b0, a_out},      (rst_n && mdl_valid) ? {7'b0, cap_a} : 8'h00);
      check("a_out_comb", {7'b0, a_out_comb}, {7'b0, a_in[a_sel]});
      check("b_out",      b_out,              (rst_n && mdl_valid) ? cap_b : 8'h00);
      check("b_out_comb", b_out_comb,         b_in[b_sel]);
      check("c_out",      {7'b0, c_out},      {7'b0, c_in[c_sel]});
      check("c_out_comb", {7'b0, c_out_comb}, {7'b0, c_in[c_sel]});
    end
  end

  // ---------------- driver tasks ----------------
  // Returns 2 time units after a rising edge; inputs change here only.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_a(input logic [3:0] v, input logic [1:0] sel);
    for (int k = 0; k < 4; k++) a_in[k] = v[k];
    a_sel = sel;
  endtask

  logic [7:0] pat8 [4];
  logic [3:0] cdat;
  logic [1:0] csel;
  logic       cexp;

  initial begin
    pat8[0] = 8'hA5; pat8[1] = 8'h3C; pat8[2] = 8'hF0; pat8[3] = 8'h0F;
    set_a(4'b1011, 2'b10);
    for (int k = 0; k < 4; k++) begin
      b_in[k] = 8'(k * 8'h11 + 8'h5A);
      c_in[k] = 1'b0;
    end
    b_sel = 2'b01;
    c_sel = 2'b00;

    // Reset with arbitrary inputs and the clock running.
    #1 rst_n = 1'b0;
    #1 check("reset_immediate_a", {7'b0, a_out}, 8'h00);
    check("reset_immediate_b", b_out, 8'h00);
    repeat (3) tick();
    check("reset_held_a", {7'b0, a_out}, 8'h00);
    check("reset_held_b", b_out, 8'h00);

    // Release, i0=1 with select 00.
    set_a(4'b0001, 2'b00);
    rst_n = 1'b1;
    #1 check("post_release_before_edge", {7'b0, a_out}, 8'h00);
    tick();
    check("post_release_load", {7'b0, a_out}, 8'h01);

    // Walking one per select code, each held several cycles.
    for (int k = 0; k < 4; k++) begin
      set_a(4'(1 << k), 2'(k));
      tick();
      check($sformatf("walk1_%0d", k), {7'b0, a_out}, 8'h01);
      repeat (2) tick();
    end

    // Exclusion: selected input 0, others 1.
    for (int k = 0; k < 4; k++) begin
      set_a(~4'(1 << k), 2'(k));
      tick();
      check($sformatf("exclude_%0d", k), {7'b0, a_out}, 8'h00);
      tick();
    end

    // Mid-operation reset pulse between edges.
    set_a(4'b1000, 2'b11);
    tick();
    check("midreset_before", {7'b0, a_out}, 8'h01);
    rst_n = 1'b0;
    #1 check("midreset_async_drop", {7'b0, a_out}, 8'h00);
    #1 rst_n = 1'b1;
    #1 check("midreset_hold_no_edge", {7'b0, a_out}, 8'h00);
    tick();
    check("midreset_recover", {7'b0, a_out}, 8'h01);

    // WIDTH=8 select sweep.
    for (int k = 0; k < 4; k++) b_in[k] = pat8[k];
    for (int k = 0; k < 4; k++) begin
      b_sel = 2'(k);
      #1 check($sformatf("w8_comb_%0d", k), b_out_comb, pat8[k]);
      tick();
      check($sformatf("w8_out_%0d", k), b_out, pat8[k]);
    end

    // Simultaneous select and data change: new select on new data.
    b_in[2] = 8'h77;
    b_sel   = 2'b10;
    tick();
    check("w8_simultaneous", b_out, 8'h77);

    // Combinational instance: all 64 input/select combinations.
    for (int v = 0; v < 64; v++) begin
      cdat = 4'(v);
      csel = 2'(v >> 4);
      for (int k = 0; k < 4; k++) c_in[k] = cdat[k];
      c_sel = csel;
      cexp  = cdat[csel];
      #1 check("comb_exh_out", {7'b0, c_out}, {7'b0, cexp});
      check("comb_exh_out_comb", {7'b0, c_out_comb}, {7'b0, cexp});
      tick();
    end

    // Reset must not disturb the combinational paths.
    c_in[1] = 1'b1;
    c_sel   = 2'b01;
    rst_n   = 1'b0;
    #1 check("comb_under_reset", {7'b0, c_out}, 8'h01);
    check("out_comb_under_reset", b_out_comb, 8'h77);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
